// File: rtl/bec_status_monitor.sv
// bec_status_monitor: watches BEC self-test checkpoint codes on the GPIO check
// bus, follows START->WRITE->PROCESS->RESULT->PASS/FAIL per test, counts
// verdicts, flags out-of-order codes and runs a progress watchdog.
// Optional macro BEC_MON_LATENCY_EN adds lat_max_o, the longest START-to-verdict
// time of any test that finished through PASS or FAIL.
module bec_status_monitor #(
  parameter int              CW      = 16,
  parameter int              IDW     = 8,
  parameter int              CNTW    = 8,
  parameter int              TOW     = 21,
  parameter int              TIMEOUT = 1500000,
  parameter logic [CW-1:0]   C_START = 16'hFD30,
  parameter logic [CW-1:0]   C_WR    = 16'hAB41,
  parameter logic [CW-1:0]   C_PROC  = 16'hAB42,
  parameter logic [CW-1:0]   C_RES   = 16'hAB51,
  parameter logic [CW-1:0]   C_PASS  = 16'hAB43,
  parameter logic [CW-1:0]   C_FAIL  = 16'hAB44,
  parameter logic [CW-1:0]   C_END   = 16'hABFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [CW-1:0]     check_i,
  input  logic [IDW-1:0]    id_i,
  output logic [2:0]        state_o,
  output logic [CNTW-1:0]   pass_cnt_o,
  output logic [CNTW-1:0]   fail_cnt_o,
  output logic [IDW-1:0]    first_fail_id_o,
  output logic              seq_err_o,
  output logic              seq_err_sticky_o,
  output logic              timeout_o,
  output logic              done_o,
  output logic              all_pass_o
`ifdef BEC_MON_LATENCY_EN
  ,
  output logic [TOW-1:0]    lat_max_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_STARTED    = 3'd1,
    S_WRITING    = 3'd2,
    S_PROCESSING = 3'd3,
    S_RESULT     = 3'd4,
    S_END        = 3'd5
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [TOW-1:0]  WD_LAST = TOW'(TIMEOUT - 1);

  logic [CW-1:0]   code_q, prev_code_q;
  state_t          state_q, state_d;
  logic [CNTW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNTW-1:0] fail_cnt_q, fail_cnt_d;
  logic [IDW-1:0]  first_fail_q, first_fail_d;
  logic [IDW-1:0]  id_lat_q, id_lat_d;
  logic            seq_err_q, seq_err_d;
  logic            sticky_q, sticky_d;
  logic            done_q, done_d;
  logic            timeout_q;
  logic [TOW-1:0]  wd_q;
  logic            evt;
  logic            seq_err;
  logic            fail_evt;

  // A code change between the registered input and the last seen code is an event.
  assign evt = (code_q != prev_code_q);

  // Input register and last-code tracker.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      code_q      <= '0;
      prev_code_q <= '0;
    end else begin
      code_q <= check_i;
      if (evt) prev_code_q <= code_q;
    end
  end

  // Checkpoint sequencer: legal advances, verdicts, and sequence-error handling.
  always_comb begin
    state_d      = state_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    id_lat_d     = id_lat_q;
    sticky_d     = sticky_q;
    done_d       = done_q;
    seq_err      = 1'b0;
    fail_evt     = 1'b0;
    if (evt && state_q != S_END) begin
      if (code_q == C_START) begin
        // A START mid-test aborts the old test as an error and begins the new one.
        seq_err  = (state_q != S_IDLE);
        state_d  = S_STARTED;
        id_lat_d = id_i;
      end else if (code_q == C_END) begin
        seq_err = (state_q != S_IDLE);
        state_d = S_END;
        done_d  = 1'b1;
      end else if (state_q == S_RESULT && code_q == C_PASS) begin
        state_d = S_IDLE;
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end else if (state_q == S_RESULT && code_q == C_FAIL) begin
        state_d  = S_IDLE;
        fail_evt = 1'b1;
      end else if (state_q == S_STARTED && code_q == C_WR) begin
        state_d = S_WRITING;
      end else if (state_q == S_WRITING && code_q == C_PROC) begin
        state_d = S_PROCESSING;
      end else if (state_q == S_PROCESSING && code_q == C_RES) begin
        state_d = S_RESULT;
      end else if (code_q inside {C_WR, C_PROC, C_RES, C_PASS, C_FAIL}) begin
        seq_err = 1'b1;
        state_d = S_IDLE;
      end
    end
    if (seq_err) begin
      sticky_d = 1'b1;
      fail_evt = 1'b1;
    end
    // Failures are attributed to the test that was running (id_lat before any relatch).
    if (fail_evt) begin
      if (fail_cnt_q == '0) first_fail_d = id_lat_q;
      if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
    end
    seq_err_d = seq_err;
  end

  // Sequencer state and result registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      id_lat_q     <= '0;
      seq_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      id_lat_q     <= id_lat_d;
      seq_err_q    <= seq_err_d;
      sticky_q     <= sticky_d;
      done_q       <= done_d;
    end
  end

  // Progress watchdog; an event on the threshold cycle wins and clears it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (evt || state_q == S_IDLE) begin
      wd_q <= '0;
    end else if (state_q != S_END && !timeout_q) begin
      if (wd_q == WD_LAST) timeout_q <= 1'b1;
      else                 wd_q      <= wd_q + 1'b1;
    end
  end

`ifdef BEC_MON_LATENCY_EN
  logic [TOW-1:0] lat_cnt_q, lat_max_q;
  logic           lat_start, lat_verdict;

  assign lat_start   = evt && state_q != S_END && code_q == C_START;
  assign lat_verdict = evt && state_q == S_RESULT && (code_q == C_PASS || code_q == C_FAIL);

  // Per-test latency counter and running maximum over completed tests.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lat_cnt_q <= '0;
      lat_max_q <= '0;
    end else begin
      if (lat_start)
        lat_cnt_q <= '0;
      else if (state_q != S_IDLE && state_q != S_END && lat_cnt_q != {TOW{1'b1}})
        lat_cnt_q <= lat_cnt_q + 1'b1;
      if (lat_verdict && lat_cnt_q > lat_max_q) lat_max_q <= lat_cnt_q;
    end
  end

  assign lat_max_o = lat_max_q;
`endif

  assign state_o          = state_q;
  assign pass_cnt_o       = pass_cnt_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign first_fail_id_o  = first_fail_q;
  assign seq_err_o        = seq_err_q;
  assign seq_err_sticky_o = sticky_q;
  assign timeout_o        = timeout_q;
  assign done_o           = done_q;
  assign all_pass_o       = done_q && (fail_cnt_q == '0) && !timeout_q;

endmodule

// File: tb/tb_bec_status_monitor.sv
// Testbench for bec_status_monitor: directed scenarios followed by randomized
// code streams, all checked against a transaction-level reference model.
// Timing convention: a code is driven just after a rising edge and held for
// `hold` edges; outputs are compared 1 time unit after the last of those edges.
// Timeout rises on edge TIMEOUT+2 after the code change; the recorded latency
// equals (cycles from driving START to driving PASS/FAIL) - 1, exactly.
module tb_bec_status_monitor;

  localparam int CW = 16, IDW = 8, CNTW = 3, TOW = 21, TIMEOUT = 100;
  localparam int CNT_MAX = (1 << CNTW) - 1;
  localparam logic [15:0] C_START = 16'hFD30, C_WR = 16'hAB41, C_PROC = 16'hAB42,
                          C_RES = 16'hAB51, C_PASS = 16'hAB43, C_FAIL = 16'hAB44,
                          C_END = 16'hABFF;

  logic            clk = 1'b0;
  logic            wb_rst_i;
  logic [CW-1:0]   check_i;
  logic [IDW-1:0]  id_i;
  logic [2:0]      state_o;
  logic [CNTW-1:0] pass_cnt_o, fail_cnt_o;
  logic [IDW-1:0]  first_fail_id_o;
  logic            seq_err_o, seq_err_sticky_o, timeout_o, done_o, all_pass_o;
`ifdef BEC_MON_LATENCY_EN
  logic [TOW-1:0]  lat_max_o;
`endif

  bec_status_monitor #(.CW(CW), .IDW(IDW), .CNTW(CNTW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .check_i(check_i), .id_i(id_i),
    .state_o(state_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .first_fail_id_o(first_fail_id_o), .seq_err_o(seq_err_o),
    .seq_err_sticky_o(seq_err_sticky_o), .timeout_o(timeout_o),
    .done_o(done_o), .all_pass_o(all_pass_o)
`ifdef BEC_MON_LATENCY_EN
    , .lat_max_o(lat_max_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Count cycles in which the sequence-error pulse is high.
  always @(negedge clk) if (seq_err_o === 1'b1) pulse_cnt++;

  // Reference model state (cumulative error count survives reset, like pulse_cnt).
  int m_state, m_pass, m_fail, m_ffid, m_idlat, m_run, m_age, m_lat_max, m_errs = 0;
  bit m_sticky, m_done, m_tout, m_tout_vis;
  logic [15:0] m_prev;

  logic [15:0] known_codes [7] = '{C_START, C_WR, C_PROC, C_RES, C_PASS, C_FAIL, C_END};
  logic [15:0] code;
  logic [7:0]  idv;
  int hold, r, n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_known(input logic [15:0] c);
    return c inside {C_START, C_WR, C_PROC, C_RES, C_PASS, C_FAIL, C_END};
  endfunction

  function automatic logic [15:0] next_expected(input int st);
    case (st)
      1: return C_WR;
      2: return C_PROC;
      3: return C_RES;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_pass = 0; m_fail = 0; m_ffid = 0; m_idlat = 0; m_run = 0;
    m_age = 0; m_lat_max = 0; m_sticky = 0; m_done = 0; m_tout = 0; m_tout_vis = 0;
    m_prev = 16'h0000;
  endtask

  task automatic model_fail();
    if (m_fail == 0) m_ffid = m_idlat;
    if (m_fail < CNT_MAX) m_fail++;
  endtask

  task automatic model_err();
    m_errs++;
    m_sticky = 1;
    model_fail();
  endtask

  // One held code = one transaction of the model.
  task automatic model_apply(input logic [15:0] c, input logic [7:0] id, input int h);
    bit counting;
    if (c != m_prev) begin
      m_prev = c;
      if (m_state != 5 && is_known(c)) begin
        if (c == C_START) begin
          if (m_state != 0) model_err();
          m_idlat = id; m_state = 1; m_age = 0;
        end else if (c == C_END) begin
          if (m_state != 0) model_err();
          m_state = 5; m_done = 1;
        end else if (m_state == 4 && (c == C_PASS || c == C_FAIL)) begin
          if (c == C_PASS) begin
            if (m_pass < CNT_MAX) m_pass++;
          end else model_fail();
          if (m_age - 1 > m_lat_max) m_lat_max = m_age - 1;
          m_state = 0;
        end else if (m_state >= 1 && m_state <= 3 && c == next_expected(m_state)) begin
          m_state++;
        end else begin
          model_err();
          m_state = 0;
        end
      end
      m_run = h;
    end else begin
      m_run += h;
    end
    counting = (m_state >= 1 && m_state <= 4);
    if (counting) m_age += h;
    m_tout_vis = m_tout || (counting && m_run >= TIMEOUT + 2);
    m_tout     = m_tout || (counting && m_run > TIMEOUT);
  endtask

  task automatic check_all();
    check("state", 32'(state_o), m_state);
    check("pass_cnt", 32'(pass_cnt_o), m_pass);
    check("fail_cnt", 32'(fail_cnt_o), m_fail);
    check("first_fail_id", 32'(first_fail_id_o), m_ffid);
    check("seq_err_sticky", 32'(seq_err_sticky_o), 32'(m_sticky));
    check("timeout", 32'(timeout_o), 32'(m_tout_vis));
    check("done", 32'(done_o), 32'(m_done));
    check("all_pass", 32'(all_pass_o), 32'(m_done && m_fail == 0 && !m_tout_vis));
    check("seq_err_pulses", pulse_cnt, m_errs);
`ifdef BEC_MON_LATENCY_EN
    check("lat_max", 32'(lat_max_o), m_lat_max);
`endif
    $display("txn t=%0t code=%h state=%0d pass=%0d fail=%0d ffid=%0h tout=%0b done=%0b",
             $time, check_i, state_o, pass_cnt_o, fail_cnt_o, first_fail_id_o, timeout_o, done_o);
  endtask

  task automatic step(input logic [15:0] c, input logic [7:0] id, input int h);
    check_i = c; id_i = id;
    repeat (h) @(posedge clk);
    #1;
    model_apply(c, id, h);
    check_all();
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; check_i = '0; id_i = '0;
    @(posedge clk); #1;
    check("rst_state", 32'(state_o), 0);
    check("rst_pass", 32'(pass_cnt_o), 0);
    check("rst_fail", 32'(fail_cnt_o), 0);
    check("rst_ffid", 32'(first_fail_id_o), 0);
    check("rst_flags", 32'({seq_err_o, seq_err_sticky_o, timeout_o, done_o, all_pass_o}), 0);
`ifdef BEC_MON_LATENCY_EN
    check("rst_lat", 32'(lat_max_o), 0);
`endif
    $display("reset t=%0t", $time);
    wb_rst_i = 1'b0;
    model_reset();
  endtask

  task automatic full_test(input logic [7:0] id, input logic [15:0] verdict);
    step(C_START, id, 10);
    step(C_WR, id, 10);
    step(C_PROC, id, 10);
    step(C_RES, id, 10);
    step(verdict, id, 10);
  endtask

  initial begin
    wb_rst_i = 1'b1; check_i = '0; id_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // 1: single passing test then END
    full_test(8'h01, C_PASS);
    step(C_END, 8'h00, 10);
    check("t1_pass", 32'(pass_cnt_o), 1);
    check("t1_all_pass", 32'(all_pass_o), 1);
    check("t1_state", 32'(state_o), 5);
    step(C_START, 8'h09, 5);        // END is absorbing
    check("t1_end_absorb", 32'(state_o), 5);

    // 2: three tests, middle one fails
    do_reset();
    full_test(8'h01, C_PASS);
    full_test(8'h02, C_FAIL);
    full_test(8'h03, C_PASS);
    step(C_END, 8'h00, 10);
    check("t2_pass", 32'(pass_cnt_o), 2);
    check("t2_fail", 32'(fail_cnt_o), 1);
    check("t2_ffid", 32'(first_fail_id_o), 2);
    check("t2_all_pass", 32'(all_pass_o), 0);

    // 3: skipped WRITE step is a sequence error; repeating a code is no event
    do_reset();
    step(C_START, 8'h07, 10);
    step(C_PROC, 8'h07, 10);
    check("t3_pulse", pulse_cnt, m_errs);
    check("t3_ffid", 32'(first_fail_id_o), 7);
    check("t3_state", 32'(state_o), 0);
    step(C_PROC, 8'h07, 5);

    // 4a: threshold coincides with event (no timeout) vs one cycle later (timeout)
    do_reset();
    step(C_START, 8'h11, TIMEOUT);
    step(C_WR, 8'h11, 5);
    check("t4_no_tout", 32'(timeout_o), 0);
    step(C_PROC, 8'h11, TIMEOUT + 1);
    step(C_RES, 8'h11, 5);
    check("t4_tout_edge", 32'(timeout_o), 1);

    // 4b: measure where timeout rises, then progress still advances state
    do_reset();
    check_i = C_START; id_i = 8'h12;
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      n = k;
      if (timeout_o === 1'b1) break;
    end
    check("t4_tout_cycle", n, TIMEOUT + 2);
    if (n < 150) begin
      repeat (150 - n) @(posedge clk);
      #1;
      n = 150;
    end
    model_apply(C_START, 8'h12, n);
    check_all();
    step(C_WR, 8'h12, 5);
    check("t4_state_after", 32'(state_o), 2);
    check("t4_sticky_tout", 32'(timeout_o), 1);

    // 5: reset in WRITING, then a clean pass
    do_reset();
    step(C_START, 8'h21, 10);
    step(C_WR, 8'h21, 10);
    do_reset();
    full_test(8'h22, C_PASS);
    check("t5_pass", 32'(pass_cnt_o), 1);

`ifdef BEC_MON_LATENCY_EN
    // 6: START-to-PASS distances of 40 and 25 cycles
    do_reset();
    step(C_START, 8'h31, 10); step(C_WR, 8'h31, 10); step(C_PROC, 8'h31, 10);
    step(C_RES, 8'h31, 10);   step(C_PASS, 8'h31, 5);
    step(C_START, 8'h32, 5);  step(C_WR, 8'h32, 5);  step(C_PROC, 8'h32, 5);
    step(C_RES, 8'h32, 10);   step(C_PASS, 8'h32, 5);
    check("t6_lat_max", 32'(lat_max_o), 39);
`endif

    // Randomized streams biased toward legal sequences
    do_reset();
    for (int t = 0; t < 250; t++) begin
      if (m_state == 5 && $urandom_range(0, 2) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          case (m_state)
            0: code = ($urandom_range(0, 9) == 0) ? C_END : C_START;
            1, 2, 3: code = next_expected(m_state);
            4: code = ($urandom_range(0, 2) == 0) ? C_FAIL : C_PASS;
            default: code = known_codes[$urandom_range(0, 6)];
          endcase
        end else if (r < 85) begin
          code = known_codes[$urandom_range(0, 6)];
        end else if (r < 93) begin
          code = m_prev;
        end else begin
          code = 16'($urandom);
          while (is_known(code)) code = 16'($urandom);
        end
        hold = ($urandom_range(0, 19) == 0) ? 150 : $urandom_range(3, 12);
        idv = 8'($urandom);
        step(code, idv, hold);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
